// File: rtl/comm_pkg.sv
// comm_pkg: shared types and protocol constants for the host
// command link (TX sequencer states, opcodes, response codes).
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  localparam logic [1:0] RD_REG = 2'b00;
  localparam logic [1:0] WR_REG = 2'b01;
  localparam logic [1:0] DUMP   = 2'b10;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

endpackage

// File: rtl/comm_master_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit
// sampling, glitch rejection and framing check.
module uart_rx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 1736
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic [15:0] baud;
  logic [15:0] baud_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_nxt;
  logic [7:0]  data_nxt;
  logic        rdy_nxt;
  logic        tick;

  assign tick = (baud == 16'd0);

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_cnt_nxt = bit_cnt;
    data_nxt    = rx_data;
    rdy_nxt     = 1'b0;
    if (state inside {RX_START, RX_DATA, RX_STOP}) begin
      baud_nxt = tick ? BAUD_M1 : baud - 16'd1;
    end
    unique case (state)
      RX_IDLE: begin
        if (prev && !sync2) begin
          baud_nxt  = HALF_M1;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (tick) begin
          bit_cnt_nxt = '0;
          state_nxt   = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick) begin
          data_nxt    = {sync2, rx_data[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rdy_nxt   = sync2;
          state_nxt = sync2 ? RX_IDLE : RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (sync2) begin
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      prev    <= 1'b1;
      state   <= RX_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      prev    <= sync2;
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= bit_cnt_nxt;
      rx_data <= data_nxt;
      rx_rdy  <= rdy_nxt;
    end
  end

endmodule

// File: rtl/comm_master.sv
// comm_master: sends 16-bit commands as two 8N1 frames (high
// byte first) and collects response bytes behind a sticky flag.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 1736
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        busy,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic        snd_q;
  logic [15:0] cmd_q;
  logic [15:0] hold;
  logic [15:0] hold_nxt;
  logic [9:0]  shift;
  logic [9:0]  shift_nxt;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_nxt;
  logic [15:0] baud;
  logic [15:0] baud_nxt;
  logic        busy_nxt;
  logic        cmplt_nxt;
  logic [7:0]  rx_data;
  logic        rx_rdy;

  // request is registered so TX/busy move one edge after snd_cmd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snd_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      snd_q <= snd_cmd;
      cmd_q <= cmd;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    baud_nxt    = baud;
    busy_nxt    = busy;
    cmplt_nxt   = cmd_cmplt;
    unique case (state)
      IDLE: begin
        if (snd_q) begin
          hold_nxt    = cmd_q;
          shift_nxt   = {1'b1, cmd_q[15:8], 1'b0};
          bit_cnt_nxt = '0;
          baud_nxt    = BAUD_M1;
          busy_nxt    = 1'b1;
          cmplt_nxt   = 1'b0;
          state_nxt   = SEND_HI;
        end
      end
      SEND_HI, SEND_LO: begin
        if (baud != 16'd0) begin
          baud_nxt = baud - 16'd1;
        end else begin
          baud_nxt = BAUD_M1;
          if (bit_cnt != 4'd9) begin
            shift_nxt   = {1'b1, shift[9:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (state == SEND_HI) begin
            // low byte start bit follows the stop bit directly
            hold_nxt    = {hold[7:0], hold[15:8]};
            shift_nxt   = {1'b1, hold[7:0], 1'b0};
            bit_cnt_nxt = '0;
            state_nxt   = SEND_LO;
          end else begin
            busy_nxt  = 1'b0;
            cmplt_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      shift     <= '1;
      bit_cnt   <= '0;
      baud      <= '0;
      busy      <= 1'b0;
      cmd_cmplt <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      baud      <= baud_nxt;
      busy      <= busy_nxt;
      cmd_cmplt <= cmplt_nxt;
    end
  end

  assign TX = shift[0];

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy)
  );

  // a new byte setting the flag beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      if (rx_rdy) begin
        resp     <= rx_data;
        resp_rdy <= 1'b1;
      end else if (clr_resp_rdy) begin
        resp_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// tb_comm_master: table-driven and randomized checks of command
// serialization, loopback reception, framing/glitch and reset.
module tb_comm_master;
  import comm_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        tx_line;
  logic        rx_line;
  logic        busy;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        loop;
  logic        rx_drv;

  int errors = 0;
  int checks = 0;
  int rdy_hi = 0;
  logic counting = 1'b0;

  logic [7:0] m_resp;
  logic       m_rdy;

  typedef struct {
    logic [15:0] c;
    int          late;
    logic [15:0] late_c;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } tx_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         glitch;
    logic       clr;
    logic [7:0] exp_resp;
    logic       exp_rdy;
  } rx_vec_t;

  tx_vec_t tv[$];
  rx_vec_t rv[$];

  assign rx_line = loop ? tx_line : rx_drv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (counting && resp_rdy) rdy_hi <= rdy_hi + 1;
  end

  comm_master #(
    .BAUD_DIV(BD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .snd_cmd     (snd_cmd),
    .TX          (tx_line),
    .RX          (rx_line),
    .busy        (busy),
    .cmd_cmplt   (cmd_cmplt),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .clr_resp_rdy(clr_resp_rdy)
  );

  task automatic chki(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", n, act, req);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, want %b", n, act, req);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] act,
                      input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", n, act, req);
    end
  endtask

  task automatic send_check(input tx_vec_t v);
    logic [9:0] fr[2];
    logic       eb;
    int         bad;
    logic [7:0] got[$];
    fr[0] = {1'b1, v.hi, 1'b0};
    fr[1] = {1'b1, v.lo, 1'b0};
    @(negedge clk);
    loop = 1'b1;
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    cmd = v.c;
    snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    snd_cmd = 1'b0;
    chk1("edge0_tx", tx_line, 1'b1);
    chk1("edge0_busy", busy, 1'b0);
    bad = 0;
    for (int cyc = 1; cyc <= 20 * BD; cyc++) begin
      @(posedge clk);
      #1;
      eb = fr[(cyc - 1) / (10 * BD)][((cyc - 1) / BD) % 10];
      if (tx_line !== eb || busy !== 1'b1 || cmd_cmplt !== 1'b0) bad++;
      if (clr_resp_rdy) begin
        chk1("clr_resp_rdy", resp_rdy, 1'b0);
        clr_resp_rdy = 1'b0;
      end else if (resp_rdy) begin
        got.push_back(resp);
        clr_resp_rdy = 1'b1;
      end
      snd_cmd = (cyc == v.late);
      if (cyc == v.late) cmd = v.late_c;
      if (cyc % BD == 0) begin
        chki($sformatf("tx_bit%0d_bad_cycles", (cyc - 1) / BD), bad, 0);
        bad = 0;
      end
    end
    @(posedge clk);
    #1;
    if (clr_resp_rdy) begin
      chk1("clr_resp_rdy", resp_rdy, 1'b0);
      clr_resp_rdy = 1'b0;
    end
    chk1("done_cmplt", cmd_cmplt, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk1("done_tx", tx_line, 1'b1);
    chki("loop_bytes", got.size(), 2);
    if (got.size() > 0) chk8("loop_hi", got[0], v.hi);
    if (got.size() > 1) chk8("loop_lo", got[1], v.lo);
    m_resp = v.lo;
    m_rdy = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    @(posedge clk);
    #3;
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (BD) @(posedge clk);
      #3;
    end
    rx_drv = 1'b1;
    repeat (2 * BD) @(posedge clk);
    #1;
  endtask

  task automatic rx_apply(input rx_vec_t v, input int idx);
    if (v.glitch > 0) begin
      @(posedge clk);
      #3;
      rx_drv = 1'b0;
      repeat (v.glitch) @(posedge clk);
      #3;
      rx_drv = 1'b1;
      repeat (3 * BD) @(posedge clk);
      #1;
    end else begin
      rx_frame(v.d, v.stop);
    end
    chk8($sformatf("rx%0d_resp", idx), resp, v.exp_resp);
    chk1($sformatf("rx%0d_rdy", idx), resp_rdy, v.exp_rdy);
    if (v.clr) begin
      clr_resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_resp_rdy = 1'b0;
      chk1($sformatf("rx%0d_clr", idx), resp_rdy, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  d;
    logic        s;
    int          g;
    logic        cl;

    rst_n = 1'b0;
    cmd = '0;
    snd_cmd = 1'b0;
    clr_resp_rdy = 1'b0;
    loop = 1'b0;
    rx_drv = 1'b1;

    rv.push_back('{POS_ACK, 1'b0, 0, 1'b0, 8'h00, 1'b0});
    rv.push_back('{NEG_ACK, 1'b1, 0, 1'b0, NEG_ACK, 1'b1});
    rv.push_back('{8'h00, 1'b1, 3, 1'b0, NEG_ACK, 1'b1});
    rv.push_back('{8'h33, 1'b1, 0, 1'b1, 8'h33, 1'b1});
    m_resp = 8'h33;
    m_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      s = ($urandom % 4) != 0;
      g = ($urandom % 5 == 0) ? int'($urandom_range(1, 5)) : 0;
      cl = 1'($urandom);
      if (g == 0 && s) begin
        m_resp = d;
        m_rdy = 1'b1;
      end
      rv.push_back('{d, s, g, cl, m_resp, m_rdy});
      if (cl) m_rdy = 1'b0;
    end

    tv.push_back('{16'h4A5C, 0, 16'h0000, 8'h4A, 8'h5C});
    tv.push_back('{16'h0123, 50, 16'hFFFF, 8'h01, 8'h23});
    for (int i = 0; i < 3; i++) begin
      c = 16'($urandom);
      tv.push_back('{c, int'($urandom_range(5, 300)), 16'($urandom),
                     8'(c >> 8), 8'(c & 16'h00FF)});
    end

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tx", tx_line, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cmplt", cmd_cmplt, 1'b0);
    chk8("rst_resp", resp, 8'h00);
    chk1("rst_rdy", resp_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (rv[i]) rx_apply(rv[i], i);
    if (resp_rdy) begin
      clr_resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_resp_rdy = 1'b0;
    end

    clr_resp_rdy = 1'b1;
    rdy_hi = 0;
    counting = 1'b1;
    rx_frame(8'h3C, 1'b1);
    counting = 1'b0;
    chki("set_wins_rdy_cycles", rdy_hi, 1);
    chk8("set_wins_resp", resp, 8'h3C);
    chk1("set_wins_rdy_after", resp_rdy, 1'b0);
    clr_resp_rdy = 1'b0;

    foreach (tv[i]) send_check(tv[i]);

    @(negedge clk);
    loop = 1'b1;
    cmd = 16'h1234;
    snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    snd_cmd = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk1("pre_rst_tx", tx_line, 1'b0);
    chk1("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_tx", tx_line, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_cmplt", cmd_cmplt, 1'b0);
    chk8("mid_rst_resp", resp, 8'h00);
    chk1("mid_rst_rdy", resp_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_check('{16'hC3A5, 0, 16'h0000, 8'hC3, 8'hA5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
